// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Signal bundle between the boot host and the instruction-memory loader.
//
//   Command : start, load_len, abort           (host -> loader)
//   Stream  : byte_valid, byte_data            (host -> loader)
//             byte_ready                       (loader -> host)
//   Memory  : wr_en, wr_addr, wr_data          (loader -> instruction memory)
//   Status  : busy, cpu_hold, done, err        (loader -> system)
//
//   master : host / system side
//   slave  : loader side
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, load_len, abort, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
    );

    modport slave (
        input  start, load_len, abort, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the instruction memory. Assembles a big-endian byte
//   stream into 32-bit words, writes them to consecutive addresses starting
//   at 0, and holds the CPU off until the image is complete.
//
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : imem_loader_if.slave
//            start/load_len/abort   load command and cancel
//            byte_valid/byte_data/byte_ready   byte stream handshake
//            wr_en/wr_addr/wr_data  instruction-memory write port
//            busy/cpu_hold/done/err status (done and err are 1-cycle pulses)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t              state;
    logic [1:0]          byte_cnt;
    logic [ADDR_W-1:0]   word_idx;
    logic [ADDR_W-1:0]   last_idx;  // load_len - 1, latched at start
    // Only the first three bytes need storing; the fourth goes straight
    // into wr_data alongside them.
    logic [DATA_W-9:0]   partial;

    logic                len_ok;
    logic [DATA_W-1:0]   next_word;

    assign len_ok    = (bus.load_len != '0) && (bus.load_len <= MAX_LEN);
    assign next_word = {partial, bus.byte_data};

    // All outputs are registered and updated together with the state, so
    // each output reflects the state it belongs to in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            word_idx       <= '0;
            last_idx       <= '0;
            partial        <= '0;
            bus.byte_ready <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.busy       <= 1'b0;
            bus.cpu_hold   <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples
            // pre-edge values; the defaults below are overridden later in
            // the same block where a pulse is wanted.
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            state          <= RECV;
                            last_idx       <= ADDR_W'(bus.load_len - (ADDR_W + 1)'(1));
                            word_idx       <= '0;
                            byte_cnt       <= '0;
                            bus.byte_ready <= 1'b1;
                            bus.busy       <= 1'b1;
                            bus.cpu_hold   <= 1'b1;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (bus.abort) begin
                        state          <= IDLE;
                        bus.err        <= 1'b1;
                        bus.byte_ready <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.cpu_hold   <= 1'b0;
                    end else if (bus.byte_valid && bus.byte_ready) begin
                        partial  <= next_word[DATA_W-9:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state          <= WRITE;
                            bus.byte_ready <= 1'b0;
                            bus.wr_en      <= 1'b1;
                            bus.wr_addr    <= word_idx;
                            bus.wr_data    <= next_word;
                        end
                    end
                end

                // The write itself is already on the bus this cycle; abort
                // only prevents further words.
                WRITE: begin
                    if (bus.abort) begin
                        state        <= IDLE;
                        bus.err      <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.cpu_hold <= 1'b0;
                    end else if (word_idx == last_idx) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        state          <= RECV;
                        word_idx       <= word_idx + ADDR_W'(1);
                        byte_cnt       <= '0;
                        bus.byte_ready <= 1'b1;
                    end
                end

                DONE: begin
                    state        <= IDLE;
                    bus.cpu_hold <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Expected writes are queued when a load
//   is issued and popped by the write monitor as the loader writes.
// ---------------------------------------------------------------------------
module tb_imem_loader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wr_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;

    int  cyc      = 0;
    int  wr_cnt   = 0;
    int  done_cnt = 0;
    int  err_cnt  = 0;
    int  hold_cnt = 0;
    int  busy_cnt = 0;
    int  done_cyc = 0;
    wr_t mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor / scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
            if (exp_q.size() == 0) begin
                check("write_unexpected", 64'(bus.wr_en), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
            end
        end
        if (bus.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bus.err === 1'b1)      err_cnt  <= err_cnt + 1;
        if (bus.cpu_hold === 1'b1) hold_cnt <= hold_cnt + 1;
        if (bus.busy === 1'b1)     busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        exp_q.push_back({ADDR_W'(addr), data});
    endtask

    task automatic start_load(input int len, output int start_cyc);
        bus.start    = 1'b1;
        bus.load_len = (ADDR_W + 1)'(len);
        start_cyc    = cyc;
        tick();
        bus.start    = 1'b0;
    endtask

    // Offers each byte until accepted, then idles for 'gap' cycles with
    // garbage on byte_data so a stray acceptance corrupts the image.
    task automatic send_bytes(input logic [7:0] bytes[$], input int gap);
        bit ok;
        for (int i = 0; i < bytes.size(); i++) begin
            ok = 1'b0;
            bus.byte_valid = 1'b1;
            bus.byte_data  = bytes[i];
            for (int t = 0; t < 50 && !ok; t++) begin
                ok = (bus.byte_ready === 1'b1);
                tick();
            end
            bus.byte_valid = 1'b0;
            bus.byte_data  = ~bytes[i];
            if (!ok) check("byte_accept_timeout", 64'(bus.byte_ready), 64'(1));
            for (int g = 0; g < gap; g++) begin
                if (i % 4 != 3) check("ready_in_gap", 64'(bus.byte_ready), 64'(1));
                tick();
            end
        end
    endtask

    task automatic wait_done(input int prev, input int max_cyc);
        int t;
        t = 0;
        while (done_cnt == prev && t < max_cyc) begin
            tick();
            t++;
        end
        if (done_cnt == prev) check("done_timeout", 64'(done_cnt), 64'(prev + 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'(0));
        check({tag, "_wr_en"},      64'(bus.wr_en),      64'(0));
        check({tag, "_wr_addr"},    64'(bus.wr_addr),    64'(0));
        check({tag, "_wr_data"},    64'(bus.wr_data),    64'(0));
        check({tag, "_busy"},       64'(bus.busy),       64'(0));
        check({tag, "_cpu_hold"},   64'(bus.cpu_hold),   64'(0));
        check({tag, "_done"},       64'(bus.done),       64'(0));
        check({tag, "_err"},        64'(bus.err),        64'(0));
    endtask

    logic [7:0] img[$];
    logic [7:0] inc[$];
    logic [7:0] part[$];
    int s, d0, e0, w0, h0, b0;

    initial begin
        bus.start      = 1'b0;
        bus.load_len   = '0;
        bus.abort      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        // Reset state
        #2;
        check_all_zero("reset");
        #10;
        reset = 1'b1;
        tick();

        // Two-word load, byte_valid held high
        img = '{8'h8C, 8'h01, 8'h00, 8'h0E, 8'hAC, 8'h01, 8'h00, 8'h0D};
        expect_write(0, 32'h8C01000E);
        expect_write(1, 32'hAC01000D);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; h0 = hold_cnt;
        start_load(2, s);
        send_bytes(img, 0);
        wait_done(d0, 100);
        check("t1_done_latency", 64'(done_cyc - s), 64'(11));
        tick();
        check("t1_hold_cycles", 64'(hold_cnt - h0), 64'(11));
        check("t1_hold_dropped", 64'(bus.cpu_hold), 64'(0));
        check("t1_writes", 64'(wr_cnt - w0), 64'(2));
        check("t1_no_err", 64'(err_cnt - e0), 64'(0));
        check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

        // Same image with three idle cycles between bytes
        expect_write(0, 32'h8C01000E);
        expect_write(1, 32'hAC01000D);
        d0 = done_cnt; w0 = wr_cnt;
        start_load(2, s);
        send_bytes(img, 3);
        wait_done(d0, 200);
        check("t2_done_latency", 64'(done_cyc - s), 64'(31));
        check("t2_writes", 64'(wr_cnt - w0), 64'(2));
        check("t2_queue_empty", 64'(exp_q.size()), 64'(0));
        tick();

        // Illegal lengths 0 and 33
        e0 = err_cnt; w0 = wr_cnt; h0 = hold_cnt; b0 = busy_cnt;
        start_load(0, s);
        tick(); tick();
        check("t3_err_len0", 64'(err_cnt - e0), 64'(1));
        start_load(33, s);
        tick(); tick();
        check("t3_err_len33", 64'(err_cnt - e0), 64'(2));
        check("t3_no_writes", 64'(wr_cnt - w0), 64'(0));
        check("t3_no_hold", 64'(hold_cnt - h0), 64'(0));
        check("t3_no_busy", 64'(busy_cnt - b0), 64'(0));

        // Full 32-word image, incrementing bytes
        for (int i = 0; i < 128; i++) inc.push_back(8'(i));
        for (int n = 0; n < 32; n++)
            expect_write(n, {8'(4*n), 8'(4*n+1), 8'(4*n+2), 8'(4*n+3)});
        d0 = done_cnt; w0 = wr_cnt;
        start_load(32, s);
        send_bytes(inc, 0);
        wait_done(d0, 400);
        check("t4_done_latency", 64'(done_cyc - s), 64'(161));
        repeat (5) tick();
        check("t4_writes", 64'(wr_cnt - w0), 64'(32));
        check("t4_done_once", 64'(done_cnt - d0), 64'(1));
        check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

        // Abort after two bytes of word 1 of a three-word load
        img  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        part = '{8'h01, 8'h02};
        expect_write(0, 32'hDEADBEEF);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        start_load(3, s);
        send_bytes(img, 0);
        send_bytes(part, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick(); tick();
        check("t5_err", 64'(err_cnt - e0), 64'(1));
        check("t5_busy_low", 64'(bus.busy), 64'(0));
        check("t5_hold_low", 64'(bus.cpu_hold), 64'(0));
        check("t5_writes", 64'(wr_cnt - w0), 64'(1));
        check("t5_no_done", 64'(done_cnt - d0), 64'(0));
        check("t5_queue_empty", 64'(exp_q.size()), 64'(0));

        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_write(0, 32'h11223344);
        d0 = done_cnt;
        start_load(1, s);
        send_bytes(img, 0);
        wait_done(d0, 50);
        check("t5_reload_latency", 64'(done_cyc - s), 64'(6));
        check("t5_reload_queue_empty", 64'(exp_q.size()), 64'(0));
        tick();

        // Asynchronous reset in the middle of RECV
        part = '{8'hAA, 8'hBB};
        start_load(2, s);
        send_bytes(part, 0);
        check("t6_ready_before_reset", 64'(bus.byte_ready), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        tick(); tick();
        reset = 1'b1;
        tick();

        img = '{8'h08, 8'h00, 8'h00, 8'h04};
        expect_write(0, 32'h08000004);
        d0 = done_cnt;
        start_load(1, s);
        send_bytes(img, 0);
        wait_done(d0, 50);
        check("t6_reload_queue_empty", 64'(exp_q.size()), 64'(0));
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
